// File: rtl/dsp48a1_if.sv
// Signal bundle for the DSP48A1-style slice.
// Cascade ports exist only with DSP48A1_CASCADE_PORTS_EN.
interface dsp48a1_if;
  logic        RSTA, RSTB, RSTC, RSTD;
  logic        RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED;
  logic        CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D;
  logic [47:0] C;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;
`ifdef DSP48A1_CASCADE_PORTS_EN
  logic [17:0] BCIN;
  logic [47:0] PCIN;
  logic        CARRYIN;
`endif

  modport master (
`ifdef DSP48A1_CASCADE_PORTS_EN
    output BCIN, PCIN, CARRYIN,
`endif
    output RSTA, RSTB, RSTC, RSTD,
    output RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
    output CEA, CEB, CEC, CED,
    output CEM, CEP, CECARRYIN, CEOPMODE,
    output A, B, D, C, OPMODE,
    input  BCOUT, M, P, PCOUT,
    input  CARRYOUT, CARRYOUTF
  );

  modport slave (
`ifdef DSP48A1_CASCADE_PORTS_EN
    input  BCIN, PCIN, CARRYIN,
`endif
    input  RSTA, RSTB, RSTC, RSTD,
    input  RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
    input  CEA, CEB, CEC, CED,
    input  CEM, CEP, CECARRYIN, CEOPMODE,
    input  A, B, D, C, OPMODE,
    output BCOUT, M, P, PCOUT,
    output CARRYOUT, CARRYOUTF
  );
endinterface

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: pre-adder, 18x18 multiplier, 48-bit post-adder.
// Define DSP48A1_CASCADE_PORTS_EN to expose BCIN/PCIN/CARRYIN.
module dsp48a1_reg #(
  parameter int W  = 18,
  parameter int EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (EN != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (ce) q <= d;
    end
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end
endmodule

module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "SYNC",
  parameter int    w18         = 18,
  parameter int    w48         = 48,
  parameter int    w36         = 36,
  parameter int    w8          = 8,
  parameter int    w1          = 1
) (
  input logic      clk,
  dsp48a1_if.slave io
);
  if (RSTTYPE != "SYNC") begin : g_bad_rst
    $error("dsp48a1_slice: only SYNC reset");
  end

  logic [w8-1:0]  op;
  logic [w18-1:0] bsrc, a0, b0, a1, b1;
  logic [w18-1:0] dr, pre, b1_d, bcin;
  logic [w48-1:0] cr, x, z, p, pcin;
  logic [w36-1:0] mul, m;
  logic [w1-1:0]  cin_d, cin, co_d, co, cyin;
  logic [w48:0]   post;

`ifdef DSP48A1_CASCADE_PORTS_EN
  assign bcin = io.BCIN;
  assign pcin = io.PCIN;
  assign cyin = io.CARRYIN;
`else
  assign bcin = '0;
  assign pcin = '0;
  assign cyin = '0;
`endif

  assign bsrc = (B_INPUT == "DIRECT")  ? io.B :
                (B_INPUT == "CASCADE") ? bcin : '0;

  dsp48a1_reg #(.W(w8), .EN(OPMODEREG)) u_op (
    .clk(clk), .rst(io.RSTOPMODE), .ce(io.CEOPMODE),
    .d(io.OPMODE), .q(op));

  dsp48a1_reg #(.W(w18), .EN(A0REG)) u_a0 (
    .clk(clk), .rst(io.RSTA), .ce(io.CEA),
    .d(io.A), .q(a0));

  dsp48a1_reg #(.W(w18), .EN(B0REG)) u_b0 (
    .clk(clk), .rst(io.RSTB), .ce(io.CEB),
    .d(bsrc), .q(b0));

  dsp48a1_reg #(.W(w18), .EN(DREG)) u_d (
    .clk(clk), .rst(io.RSTD), .ce(io.CED),
    .d(io.D), .q(dr));

  dsp48a1_reg #(.W(w48), .EN(CREG)) u_c (
    .clk(clk), .rst(io.RSTC), .ce(io.CEC),
    .d(io.C), .q(cr));

  // Pre-adder wraps at 18 bits by construction.
  assign pre  = op[6] ? dr - b0 : dr + b0;
  assign b1_d = op[4] ? pre : b0;

  dsp48a1_reg #(.W(w18), .EN(A1REG)) u_a1 (
    .clk(clk), .rst(io.RSTA), .ce(io.CEA),
    .d(a0), .q(a1));

  dsp48a1_reg #(.W(w18), .EN(B1REG)) u_b1 (
    .clk(clk), .rst(io.RSTB), .ce(io.CEB),
    .d(b1_d), .q(b1));

  assign mul = w36'(a1) * w36'(b1);

  dsp48a1_reg #(.W(w36), .EN(MREG)) u_m (
    .clk(clk), .rst(io.RSTM), .ce(io.CEM),
    .d(mul), .q(m));

  assign cin_d = (CARRYINSEL == "OPMODE5") ? op[5] :
                 (CARRYINSEL == "CARRYIN") ? cyin : '0;

  dsp48a1_reg #(.W(w1), .EN(CARRYINREG)) u_cin (
    .clk(clk), .rst(io.RSTCARRYIN), .ce(io.CECARRYIN),
    .d(cin_d), .q(cin));

  always_comb begin
    x = '0;
    case (op[1:0])
      2'd0: x = '0;
      2'd1: x = w48'(m);
      2'd2: x = p;
      2'd3: x = {dr[11:0], a1, b1};
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    case (op[3:2])
      2'd0: z = '0;
      2'd1: z = pcin;
      2'd2: z = p;
      2'd3: z = cr;
      default: z = '0;
    endcase
  end

  // Subtract mode leaves the borrow in bit 48.
  always_comb begin
    if (op[7])
      post = {1'b0, z} - ({1'b0, x} + (w48+1)'(cin));
    else
      post = {1'b0, z} + {1'b0, x} + (w48+1)'(cin);
  end

  assign co_d = post[w48];

  dsp48a1_reg #(.W(w48), .EN(PREG)) u_p (
    .clk(clk), .rst(io.RSTP), .ce(io.CEP),
    .d(post[w48-1:0]), .q(p));

  dsp48a1_reg #(.W(w1), .EN(CARRYOUTREG)) u_co (
    .clk(clk), .rst(io.RSTP), .ce(io.CEP),
    .d(co_d), .q(co));

  assign io.BCOUT     = b1;
  assign io.M         = m;
  assign io.P         = p;
  assign io.PCOUT     = p;
  assign io.CARRYOUT  = co;
  assign io.CARRYOUTF = co;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice with default parameters.
// Random and directed stimulus against a per-edge reference model.
module tb_dsp48a1_slice;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  dsp48a1_if bus ();

  dsp48a1_slice dut (
    .clk(clk),
    .io (bus)
  );

  typedef struct {
    bit [7:0]  rst;
    bit [7:0]  ce;
    bit [17:0] a, b, d;
    bit [47:0] c;
    bit [7:0]  op;
  } stim_t;

  typedef struct {
    longint unsigned bcout, m, p, co;
  } exp_t;

  localparam longint unsigned MSK18 = 64'h3_FFFF;
  localparam longint unsigned MSK12 = 64'hFFF;
  localparam longint unsigned MSK48 = 64'hFFFF_FFFF_FFFF;

  stim_t s;
  exp_t  sbq[$];
  int    total = 0;
  int    passed = 0;

  longint unsigned mop, mdr, mcr, ma1, mb1, mm, mcin, mp, mco;

  task automatic chk(string name, longint unsigned act,
                     longint unsigned req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h expected %0h t=%0t",
                  name, act, req, $time);
  endtask

  function automatic longint unsigned upd(
    bit rst, bit ce, longint unsigned nv, longint unsigned ov);
    return rst ? 64'd0 : (ce ? nv : ov);
  endfunction

  // Indices: 0 A,1 B,2 C,3 D,4 M,5 P,6 CARRYIN,7 OPMODE
  task automatic model_step();
    longint unsigned pre, b1n, prod, x, z, sum, tot;
    longint unsigned bv, co_n;
    bv   = longint'(s.b);
    pre  = (mop[6] ? mdr - bv : mdr + bv) & MSK18;
    b1n  = mop[4] ? pre : bv;
    prod = ma1 * mb1;
    case (mop[1:0])
      2'd0: x = 0;
      2'd1: x = mm;
      2'd2: x = mp;
      default: x = ((mdr & MSK12) << 36) | (ma1 << 18) | mb1;
    endcase
    case (mop[3:2])
      2'd2: z = mp;
      2'd3: z = mcr;
      default: z = 0;
    endcase
    if (mop[7]) begin
      tot  = x + mcin;
      co_n = (z < tot) ? 1 : 0;
      sum  = (z - tot) & MSK48;
    end else begin
      tot  = z + x + mcin;
      co_n = tot >> 48;
      sum  = tot & MSK48;
    end
    mcin = upd(s.rst[6], s.ce[6], mop[5], mcin);
    mp   = upd(s.rst[5], s.ce[5], sum, mp);
    mco  = upd(s.rst[5], s.ce[5], co_n, mco);
    mm   = upd(s.rst[4], s.ce[4], prod, mm);
    ma1  = upd(s.rst[0], s.ce[0], longint'(s.a), ma1);
    mb1  = upd(s.rst[1], s.ce[1], b1n, mb1);
    mdr  = upd(s.rst[3], s.ce[3], longint'(s.d), mdr);
    mcr  = upd(s.rst[2], s.ce[2], longint'(s.c), mcr);
    mop  = upd(s.rst[7], s.ce[7], longint'(s.op), mop);
  endtask

  task automatic drive();
    {bus.RSTOPMODE, bus.RSTCARRYIN, bus.RSTP, bus.RSTM,
     bus.RSTD, bus.RSTC, bus.RSTB, bus.RSTA} = s.rst;
    {bus.CEOPMODE, bus.CECARRYIN, bus.CEP, bus.CEM,
     bus.CED, bus.CEC, bus.CEB, bus.CEA} = s.ce;
    bus.A = s.a;
    bus.B = s.b;
    bus.D = s.d;
    bus.C = s.c;
    bus.OPMODE = s.op;
`ifdef DSP48A1_CASCADE_PORTS_EN
    bus.BCIN = '0;
    bus.PCIN = '0;
    bus.CARRYIN = 1'b0;
`endif
  endtask

  task automatic cyc(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive();
      model_step();
      e.bcout = mb1;
      e.m = mm;
      e.p = mp;
      e.co = mco;
      sbq.push_back(e);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_bcout", bus.BCOUT, e.bcout);
        chk("sb_m", bus.M, e.m);
        chk("sb_p", bus.P, e.p);
        chk("sb_pcout", bus.PCOUT, e.p);
        chk("sb_carryout", bus.CARRYOUT, e.co);
        chk("sb_carryoutf", bus.CARRYOUTF, e.co);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic set(bit [17:0] a, bit [17:0] b, bit [17:0] d,
                     bit [47:0] c, bit [7:0] op);
    s.rst = '0;
    s.ce  = '1;
    s.a = a; s.b = b; s.d = d; s.c = c; s.op = op;
  endtask

  initial begin : stim
    {mop, mdr, mcr, ma1, mb1, mm, mcin, mp, mco} = '0;

    // Reset with random data and enables
    s.rst = '1;
    s.ce  = 8'($urandom);
    s.a = 18'($urandom); s.b = 18'($urandom);
    s.d = 18'($urandom);
    s.c = {16'($urandom), 32'($urandom)};
    s.op = 8'($urandom);
    cyc(1);
    chk("rst_p", bus.P, 0);
    chk("rst_m", bus.M, 0);
    chk("rst_bcout", bus.BCOUT, 0);
    chk("rst_carryout", bus.CARRYOUT, 0);
    chk("rst_carryoutf", bus.CARRYOUTF, 0);

    set(3, 5, 0, 0, 8'h01);
    cyc(4);
    chk("mul_bcout", bus.BCOUT, 5);
    chk("mul_m", bus.M, 15);
    chk("mul_p", bus.P, 15);
    chk("mul_co", bus.CARRYOUT, 0);

    set(2, 4, 10, 0, 8'h51);
    cyc(5);
    chk("pre_bcout", bus.BCOUT, 6);
    chk("pre_m", bus.M, 12);
    chk("pre_p", bus.P, 12);

    set(3, 5, 0, 100, 8'h0D);
    cyc(5);
    chk("cadd_p", bus.P, 115);
    set(3, 5, 0, 100, 8'h8D);
    cyc(5);
    chk("csub_p", bus.P, 85);

    set(0, 0, 0, 48'hFFFF_FFFF_FFFF, 8'h2C);
    cyc(4);
    chk("wrap_p", bus.P, 0);
    chk("wrap_co", bus.CARRYOUT, 1);
    chk("wrap_cof", bus.CARRYOUTF, 1);

    set(1, 1, 0, 0, 8'h09);
    s.rst[5] = 1'b1;
    cyc(4);
    chk("acc_clr", bus.P, 0);
    s.rst[5] = 1'b0;
    cyc(5);
    chk("acc_p5", bus.P, 5);
    s.ce[5] = 1'b0;
    cyc(3);
    chk("acc_hold", bus.P, 5);
    s.rst[5] = 1'b1;
    cyc(1);
    chk("acc_rst_ce0", bus.P, 0);

    // Randomized phase with sparse resets and enable gaps
    for (int k = 0; k < 300; k++) begin
      s.a = 18'($urandom);
      s.b = 18'($urandom);
      s.d = 18'($urandom);
      s.c = {16'($urandom), 32'($urandom)};
      s.op = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        s.ce[j]  = ($urandom_range(0, 9) != 0);
        s.rst[j] = ($urandom_range(0, 49) == 0);
      end
      cyc(1);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dsp48a1_slice.md
Name: dsp48a1_slice

Overview:
- Parameterised DSP slice modelled on the Spartan-6 DSP48A1.
- Datapath: 18-bit pre-adder/subtractor, 18x18 multiplier, and 48-bit post-adder/subtractor/accumulator with carry.
- Each pipeline stage is a register that can be enabled or bypassed.
- Used as the arithmetic core for MAC and filter datapaths.

Parameters:
- A0REG, 0: 1 = register A at stage 0; 0 = bypass.
- A1REG, 1: stage-1 register on A.
- B0REG, 0: stage-0 register on B.
- B1REG, 1: stage-1 register on the B/pre-adder path.
- CREG, 1: C input register.
- DREG, 1: D input register.
- MREG, 1: multiplier output register.
- PREG, 1: P output register.
- CARRYINREG, 1: carry-in register.
- CARRYOUTREG, 1: carry-out register.
- OPMODEREG, 1: OPMODE register.
- CARRYINSEL, "OPMODE5": carry-in source, "OPMODE5" or "CARRYIN". Any other value gives carry-in 0.
- B_INPUT, "DIRECT": B source, "DIRECT" = B port, "CASCADE" = BCIN. Any other value gives 0.
- RSTTYPE, "SYNC": fixed; only "SYNC" is implemented.
- w18, 18: A/B/D/BCOUT width.
- w48, 48: C/P/PCOUT width.
- w36, 36: M width.
- w8, 8: OPMODE width.
- w1, 1: single-bit width.
- Only default widths are supported.

Ports:
- clk  in  1  sole clock; all registers update on its rising edge.
- RSTA/RSTB/RSTC/RSTD/RSTM/RSTP/RSTCARRYIN/RSTOPMODE  in  1 each  synchronous active-high resets for the A, B, C, D, M, P (also CARRYOUT), carry-in and OPMODE registers.
- CEA/CEB/CEC/CED/CEM/CEP/CECARRYIN/CEOPMODE  in  1 each  clock enables for the same registers.
- A  in  18  multiplier operand.
- B  in  18  pre-adder/multiplier operand.
- D  in  18  pre-adder operand.
- C  in  48  post-adder operand.
- OPMODE  in  8  operation select.
- BCOUT  out  18  B1 stage output.
- M  out  36  multiplier product after MREG stage.
- P  out  48  result.
- PCOUT  out  48  copy of P.
- CARRYOUT  out  1  post-adder carry.
- CARRYOUTF  out  1  copy of CARRYOUT.

Behaviour:
- Register rules (every stage):
  - Reset is synchronous, active-high and has priority over CE; the register clears to 0.
  - Otherwise the register loads when CE=1 and holds when CE=0.
  - When a stage's parameter is 0, the stage is a wire; its RST and CE are ignored.
- After one cycle with all RSTs high: P=0, PCOUT=0, M=0, BCOUT=0, CARRYOUT=0, CARRYOUTF=0.
- Notation: op = OPMODE after the OPMODE stage. op controls every mux.
- Stage 0: A0 = A; B0 = B (or BCIN when B_INPUT="CASCADE"); Dr = D; Cr = C. Each goes through its own stage.
- Pre-adder: pre = op[6] ? Dr - B0 : Dr + B0. Result is 18 bits, wrapping modulo 2^18.
- Stage 1: B1 input = op[4] ? pre : B0; A1 = A0 after the A1 stage. BCOUT = B1.
- Multiplier: B1*A1, unsigned, 36 bits, through the MREG stage. Its output is M.
- X mux by op[1:0]:
  - 0 = 0
  - 1 = M zero-extended to 48 bits
  - 2 = P
  - 3 = {Dr[11:0], A1, B1}
- Z mux by op[3:2]:
  - 0 = 0
  - 1 = PCIN
  - 2 = P
  - 3 = Cr
- Carry-in: CIN = op[5] when CARRYINSEL="OPMODE5", else the CARRYIN port. It passes through the carry-in stage.
- Post-adder, 49-bit result {co, sum}:
  - op[7]=0: Z + X + CIN
  - op[7]=1: Z - (X + CIN)
  - For subtract, co is the borrow bit (bit 48 of the 49-bit two's-complement result).
- Output stage: sum goes through PREG to P; co goes through CARRYOUTREG to CARRYOUT. PCOUT = P; CARRYOUTF = CARRYOUT.
- Latency: with defaults and inputs held steady, P is valid 3 edges after A/B/OPMODE are sampled (A1/B1, then M, then P). The D/C paths add their input stage.
- Accumulate (Z=P, X=M): P adds M every enabled cycle and wraps modulo 2^48.
- Reset mid-operation clears only the addressed register. Downstream stages pick up the zero on later edges.

Optional Feature:
- Macro DSP48A1_CASCADE_PORTS_EN.
- Defined: adds input ports BCIN[17:0], PCIN[47:0] and CARRYIN[0:0], used as described above.
- Undefined: these ports do not exist and are tied to 0 internally. B_INPUT="CASCADE" then yields B0=0, Z-mux code 1 yields 0, and CARRYINSEL="CARRYIN" yields CIN=0.

Test Plan:
- All RSTs=1 for one edge with random inputs -> P=0, M=0, BCOUT=0, CARRYOUT=0, CARRYOUTF=0.
- A=3, B=5, OPMODE=8'h01, all CE=1, held 4 cycles -> BCOUT=5, M=15, P=15, CARRYOUT=0.
- D=10, B=4, A=2, OPMODE=8'h51, held 5 cycles -> BCOUT=6, M=12, P=12.
- A=3, B=5, C=100: OPMODE=8'h0D -> P=115; then OPMODE=8'h8D -> P=85.
- C=48'hFFFF_FFFF_FFFF, OPMODE=8'h2C -> P=0, CARRYOUT=1, CARRYOUTF=1.
- A=1, B=1, OPMODE=8'h09 after P reset -> P increments by 1 per cycle; CEP=0 freezes P; RSTP=1 with CEP=0 -> P=0 next edge.
